// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload + valid, multi-cycle carry channel,
// flush, and a saturating count of cycles since the last load.
module pipe_stage_reg #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CARRY_W   = 66,
    parameter int unsigned NSTALL    = 6,
    parameter int unsigned STAGE_IDX = 3,
    parameter int unsigned CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSTALL-1:0]  stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CARRY_W-1:0] carry_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [CARRY_W-1:0] carry_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    if (STAGE_IDX >= NSTALL || DATA_W < 1 || CARRY_W < 1) begin : g_param_check
        $error("pipe_stage_reg: illegal parameterisation");
    end

    typedef enum logic [1:0] {
        ActClear,
        ActBubble,
        ActLoad,
        ActHold
    } action_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic       up_stop;
    logic       dn_stop;
    action_e    action;
    logic [CNT_W-1:0] cnt_sat_inc;

    assign up_stop = stall[STAGE_IDX];

    // The last stage has no downstream stall bit to honour.
    if (STAGE_IDX + 1 < NSTALL) begin : g_dn_stop
        assign dn_stop = stall[STAGE_IDX+1];
    end else begin : g_top_stage
        assign dn_stop = 1'b0;
    end

    assign cnt_sat_inc = (stall_cnt_o == CntMax) ? CntMax : stall_cnt_o + CNT_W'(1);

    always_comb begin
        action = ActLoad;
        if (rst || flush) begin
            action = ActClear;
        end else if (up_stop && !dn_stop) begin
            action = ActBubble;
        end else if (!up_stop) begin
            action = ActLoad;
        end else begin
            action = ActHold;
        end
    end

    always_ff @(posedge clk) begin
        unique case (action)
            ActClear: begin
                out_valid   <= 1'b0;
                out_data    <= '0;
                carry_o     <= '0;
                stall_cnt_o <= '0;
            end
            ActBubble: begin
                out_valid   <= 1'b0;
                out_data    <= '0;
                carry_o     <= carry_i;
                stall_cnt_o <= cnt_sat_inc;
            end
            ActLoad: begin
                out_valid   <= in_valid;
                out_data    <= in_data;
                carry_o     <= '0;
                stall_cnt_o <= '0;
            end
            ActHold: begin
                // Payload is kept; carry keeps tracking the in-flight multi-cycle op.
                carry_o     <= carry_i;
                stall_cnt_o <= cnt_sat_inc;
            end
            default: begin
                out_valid   <= 1'b0;
                out_data    <= '0;
                carry_o     <= '0;
                stall_cnt_o <= '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed plan steps plus random stimulus,
// compared against a behavioural model for a middle stage and the top stage.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [65:0] carry_i;

    logic        ov3, ov5;
    logic [31:0] od3, od5;
    logic [65:0] co3, co5;
    logic [3:0]  sc3, sc5;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [65:0] c;
        logic [3:0]  n;
    } st_t;

    st_t m3, m5;

    pipe_stage_reg #(.DATA_W(32), .CARRY_W(66), .NSTALL(6), .STAGE_IDX(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .carry_i(carry_i), .out_valid(ov3), .out_data(od3),
        .carry_o(co3), .stall_cnt_o(sc3)
    );

    pipe_stage_reg #(.DATA_W(32), .CARRY_W(66), .NSTALL(6), .STAGE_IDX(5), .CNT_W(4)) dut_top (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .carry_i(carry_i), .out_valid(ov5), .out_data(od5),
        .carry_o(co5), .stall_cnt_o(sc5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: state after one edge, straight from the action priority list.
    function automatic st_t model_next(st_t s, int idx, logic r, logic [5:0] stl, logic fl,
                                       logic v, logic [31:0] d, logic [65:0] c);
        st_t o;
        logic up, dn;
        int cnt;
        o = s;
        up = stl[idx];
        dn = 1'b0;
        if (idx + 1 < 6) dn = stl[idx+1];
        cnt = int'(s.n) + 1;
        if (cnt > 15) cnt = 15;
        if (r || fl) begin
            o = '0;
        end else if (up && !dn) begin
            o.v = 1'b0; o.d = '0; o.c = c; o.n = 4'(cnt);
        end else if (!up) begin
            o.v = v; o.d = d; o.c = '0; o.n = '0;
        end else begin
            o.c = c; o.n = 4'(cnt);
        end
        return o;
    endfunction

    task automatic check_all();
        total++; assert (ov3 === m3.v) else begin bad++;
            $error("FAIL s3_valid got=%0b exp=%0b", ov3, m3.v); end
        total++; assert (od3 === m3.d) else begin bad++;
            $error("FAIL s3_data got=%h exp=%h", od3, m3.d); end
        total++; assert (co3 === m3.c) else begin bad++;
            $error("FAIL s3_carry got=%h exp=%h", co3, m3.c); end
        total++; assert (sc3 === m3.n) else begin bad++;
            $error("FAIL s3_cnt got=%0d exp=%0d", sc3, m3.n); end
        total++; assert (ov5 === m5.v) else begin bad++;
            $error("FAIL s5_valid got=%0b exp=%0b", ov5, m5.v); end
        total++; assert (od5 === m5.d) else begin bad++;
            $error("FAIL s5_data got=%h exp=%h", od5, m5.d); end
        total++; assert (co5 === m5.c) else begin bad++;
            $error("FAIL s5_carry got=%h exp=%h", co5, m5.c); end
        total++; assert (sc5 === m5.n) else begin bad++;
            $error("FAIL s5_cnt got=%0d exp=%0d", sc5, m5.n); end
    endtask

    task automatic step(input logic r, input logic [5:0] s, input logic f, input logic v,
                        input logic [31:0] d, input logic [65:0] c);
        rst = r; stall = s; flush = f; in_valid = v; in_data = d; carry_i = c;
        @(posedge clk);
        m3 = model_next(m3, 3, r, s, f, v, d, c);
        m5 = model_next(m5, 5, r, s, f, v, d, c);
        #1;
        check_all();
    endtask

    initial begin
        logic [95:0] rnd;
        logic [65:0] rc;
        logic [5:0]  rs;
        m3 = '0; m5 = '0;
        rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; carry_i = '0;

        // Reset with live inputs, then first load.
        step(1'b1, 6'b0, 1'b0, 1'b1, 32'hDEADBEEF, 66'h0);
        step(1'b1, 6'b0, 1'b0, 1'b1, 32'hDEADBEEF, 66'h0);
        total++; assert (od3 === 32'h0 && ov3 === 1'b0) else begin bad++;
            $error("FAIL reset_out got=%h/%0b exp=0/0", od3, ov3); end
        step(1'b0, 6'b0, 1'b0, 1'b1, 32'hDEADBEEF, 66'h0);
        total++; assert (od3 === 32'hDEADBEEF && ov3 === 1'b1) else begin bad++;
            $error("FAIL first_load got=%h/%0b exp=deadbeef/1", od3, ov3); end

        // Load stream.
        for (int i = 1; i <= 3; i++) step(1'b0, 6'b0, 1'b0, 1'b1, 32'(i), 66'h0);

        // Bubble then reload.
        step(1'b0, 6'b001000, 1'b0, 1'b1, 32'h55, 66'h3_0000_0001);
        total++; assert (co3 === 66'h3_0000_0001 && sc3 === 4'd1 && ov3 === 1'b0) else begin
            bad++; $error("FAIL bubble got=%h/%0d/%0b exp=300000001/1/0", co3, sc3, ov3); end
        step(1'b0, 6'b000000, 1'b0, 1'b1, 32'h55, 66'h3_0000_0001);
        total++; assert (od3 === 32'h55 && co3 === 66'h0) else begin bad++;
            $error("FAIL bubble_reload got=%h/%h exp=55/0", od3, co3); end

        // Hold with saturation.
        step(1'b0, 6'b000000, 1'b0, 1'b1, 32'hA5, 66'h0);
        for (int i = 0; i < 20; i++) step(1'b0, 6'b011000, 1'b0, 1'b0, 32'h0, 66'(i + 100));
        total++; assert (od3 === 32'hA5 && ov3 === 1'b1 && sc3 === 4'd15 && co3 === 66'd119)
            else begin bad++;
            $error("FAIL hold_sat got=%h/%0b/%0d/%0d exp=a5/1/15/119", od3, ov3, sc3, co3); end

        // Flush beats both stall bits.
        step(1'b0, 6'b011000, 1'b1, 1'b1, 32'h77, 66'h5);
        total++; assert (ov3 === 1'b0 && od3 === 32'h0 && co3 === 66'h0 && sc3 === 4'd0)
            else begin bad++; $error("FAIL flush got=%0b/%h/%h/%0d exp=0/0/0/0",
                                      ov3, od3, co3, sc3); end

        // Top stage: only its own bit set means bubble.
        step(1'b0, 6'b000000, 1'b0, 1'b1, 32'h12, 66'h0);
        step(1'b0, 6'b100000, 1'b0, 1'b1, 32'h34, 66'h9);
        total++; assert (ov5 === 1'b0 && od5 === 32'h0 && co5 === 66'h9 && sc5 === 4'd1)
            else begin bad++; $error("FAIL top_bubble got=%0b/%h/%h/%0d exp=0/0/9/1",
                                      ov5, od5, co5, sc5); end

        // Random traffic, mostly monotone stall vectors with occasional arbitrary ones.
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            rc = rnd[65:0];
            if ($urandom_range(0, 3) == 0) rs = 6'($urandom);
            else rs = 6'(6'h3f << $urandom_range(0, 6));
            step(($urandom_range(0, 40) == 0), rs, ($urandom_range(0, 15) == 0),
                 1'($urandom), $urandom, rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
